// File: rtl/pipe_hazard_ctrl.sv
// Hazard and forwarding controller: tracks in-flight destination tags from EX to WB and
// drives the decode stall and operand forwarding selects. Define PIPE_HAZARD_FORWARDING_EN to enable forwarding.
module pipe_hazard_ctrl #(
  parameter int REG_INDEX_BIT_WIDTH = 4,
  parameter int PIPE_DEPTH          = 3,
  parameter int LOAD_FWD_STAGE      = 2,
  parameter int HARDWIRED_ZERO      = 0,
  localparam int FSEL_W             = $clog2(PIPE_DEPTH + 1)
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           dec_valid,
  input  logic [REG_INDEX_BIT_WIDTH-1:0] dec_src1,
  input  logic [REG_INDEX_BIT_WIDTH-1:0] dec_src2,
  input  logic                           dec_use_src1,
  input  logic                           dec_use_src2,
  input  logic                           dec_wr_reg,
  input  logic [REG_INDEX_BIT_WIDTH-1:0] dec_dest,
  input  logic                           dec_is_load,
  input  logic                           flush,
  output logic                           stall,
  output logic [FSEL_W-1:0]              fwd_sel1,
  output logic [FSEL_W-1:0]              fwd_sel2,
  output logic [PIPE_DEPTH-1:0]          tag_valid,
  output logic [31:0]                    stall_cnt
);

  // Bit/element k-1 of each vector describes back-end stage k (stage 1 = EX).
  logic [PIPE_DEPTH-1:0]                          vld_p;
  logic [PIPE_DEPTH-1:0][REG_INDEX_BIT_WIDTH-1:0] dest_p;
  logic [PIPE_DEPTH-1:0]                          load_p;

  logic [FSEL_W-1:0] sel1, sel2;
  logic              raw_stall;
  logic              ent_vld;

  function automatic logic is_zero_reg(input logic [REG_INDEX_BIT_WIDTH-1:0] idx);
    return (HARDWIRED_ZERO != 0) && (idx == '0);
  endfunction

  // Youngest producer wins: scan from oldest to youngest so the lowest stage overwrites.
  function automatic logic [FSEL_W-1:0] find_producer(
    input logic                                          use_src,
    input logic [REG_INDEX_BIT_WIDTH-1:0]                src,
    input logic [PIPE_DEPTH-1:0]                         vld,
    input logic [PIPE_DEPTH-1:0][REG_INDEX_BIT_WIDTH-1:0] dest
  );
    logic [FSEL_W-1:0] sel;
    sel = '0;
    for (int k = PIPE_DEPTH; k >= 1; k--) begin
      if (use_src && vld[k-1] && (dest[k-1] == src) && !is_zero_reg(src))
        sel = FSEL_W'(k);
    end
    return sel;
  endfunction

`ifdef PIPE_HAZARD_FORWARDING_EN
  function automatic logic load_too_young(
    input logic [FSEL_W-1:0]     sel,
    input logic [PIPE_DEPTH-1:0] load
  );
    logic hit;
    hit = 1'b0;
    for (int k = 1; k <= PIPE_DEPTH; k++) begin
      if ((sel == FSEL_W'(k)) && load[k-1] && (k < LOAD_FWD_STAGE))
        hit = 1'b1;
    end
    return hit;
  endfunction
`endif

  always_comb begin
    sel1 = find_producer(dec_valid && dec_use_src1, dec_src1, vld_p, dest_p);
    sel2 = find_producer(dec_valid && dec_use_src2, dec_src2, vld_p, dest_p);
`ifdef PIPE_HAZARD_FORWARDING_EN
    raw_stall = load_too_young(sel1, load_p) || load_too_young(sel2, load_p);
`else
    raw_stall = (sel1 != '0) || (sel2 != '0);
`endif
    // A redirect kills the decode slot, so there is nothing left to hold.
    stall = raw_stall && !flush;
`ifdef PIPE_HAZARD_FORWARDING_EN
    fwd_sel1 = stall ? '0 : sel1;
    fwd_sel2 = stall ? '0 : sel2;
`else
    fwd_sel1 = '0;
    fwd_sel2 = '0;
`endif
    ent_vld = dec_valid && dec_wr_reg && !flush && !stall && !is_zero_reg(dec_dest);
  end

`ifndef PIPE_HAZARD_FORWARDING_EN
  logic unused_load;
  assign unused_load = ^load_p;
`endif

  assign tag_valid = vld_p;

  // Tag pipe stage boundary: decode -> EX -> ... -> WB, advancing every clock.
  always_ff @(posedge clk) begin
    if (!reset) begin
      vld_p     <= '0;
      stall_cnt <= '0;
    end else begin
      vld_p <= {vld_p[PIPE_DEPTH-2:0], ent_vld};
      if (stall && (stall_cnt != 32'hFFFF_FFFF))
        stall_cnt <= stall_cnt + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    dest_p <= {dest_p[PIPE_DEPTH-2:0], dec_dest};
    load_p <= {load_p[PIPE_DEPTH-2:0], dec_is_load};
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: u0 uses defaults (depth 3), u1 uses depth 5 with
// hardwired zero. Expectations adapt to whether PIPE_HAZARD_FORWARDING_EN is defined.
module tb_pipe_hazard_ctrl;
`ifdef PIPE_HAZARD_FORWARDING_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       dec_valid = 1'b0, dec_use_src1 = 1'b0, dec_use_src2 = 1'b0;
  logic       dec_wr_reg = 1'b0, dec_is_load = 1'b0, flush = 1'b0;
  logic [3:0] dec_src1 = '0, dec_src2 = '0, dec_dest = '0;

  logic        st0, st1;
  logic [1:0]  f1_0, f2_0;
  logic [2:0]  f1_1, f2_1;
  logic [2:0]  tv0;
  logic [4:0]  tv1;
  logic [31:0] cnt0, cnt1;

  always #5 clk = ~clk;

  pipe_hazard_ctrl u0 (
    .clk(clk), .reset(reset), .dec_valid(dec_valid), .dec_src1(dec_src1), .dec_src2(dec_src2),
    .dec_use_src1(dec_use_src1), .dec_use_src2(dec_use_src2), .dec_wr_reg(dec_wr_reg),
    .dec_dest(dec_dest), .dec_is_load(dec_is_load), .flush(flush), .stall(st0),
    .fwd_sel1(f1_0), .fwd_sel2(f2_0), .tag_valid(tv0), .stall_cnt(cnt0)
  );

  pipe_hazard_ctrl #(.PIPE_DEPTH(5), .HARDWIRED_ZERO(1)) u1 (
    .clk(clk), .reset(reset), .dec_valid(dec_valid), .dec_src1(dec_src1), .dec_src2(dec_src2),
    .dec_use_src1(dec_use_src1), .dec_use_src2(dec_use_src2), .dec_wr_reg(dec_wr_reg),
    .dec_dest(dec_dest), .dec_is_load(dec_is_load), .flush(flush), .stall(st1),
    .fwd_sel1(f1_1), .fwd_sel2(f2_1), .tag_valid(tv1), .stall_cnt(cnt1)
  );

  typedef struct {
    int dut;
    int id;
    int st;
    int f1;
    int f2;
    int tv;
    int cnt;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   step_no = 0;

  task automatic check(input string name, input int id, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s step %0d: got %0d, expected %0d", name, id, act, exp);
    end
  endtask

  // Monitor: outputs are combinational, so each pushed vector is checked mid-cycle.
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      if (e.dut == 0) begin
        check("stall", e.id, int'(st0), e.st);
        check("fwd_sel1", e.id, int'(f1_0), e.f1);
        check("fwd_sel2", e.id, int'(f2_0), e.f2);
        check("tag_valid", e.id, int'(tv0), e.tv);
        check("stall_cnt", e.id, int'(cnt0), e.cnt);
      end else begin
        check("stall", e.id, int'(st1), e.st);
        check("fwd_sel1", e.id, int'(f1_1), e.f1);
        check("fwd_sel2", e.id, int'(f2_1), e.f2);
        check("tag_valid", e.id, int'(tv1), e.tv);
        check("stall_cnt", e.id, int'(cnt1), e.cnt);
      end
    end
  end

  task automatic drive(input int v, input int u1, input int s1, input int u2, input int s2,
                       input int wr, input int d, input int ld, input int fl);
    dec_valid    = 1'(v);
    dec_use_src1 = 1'(u1);
    dec_src1     = 4'(s1);
    dec_use_src2 = 1'(u2);
    dec_src2     = 4'(s2);
    dec_wr_reg   = 1'(wr);
    dec_dest     = 4'(d);
    dec_is_load  = 1'(ld);
    flush        = 1'(fl);
  endtask

  // step(dut, valid, use1, src1, use2, src2, wr, dest, load, flush, exp stall, f1, f2, tag_valid, cnt)
  task automatic step(input int dut, input int v, input int u1, input int s1, input int u2,
                      input int s2, input int wr, input int d, input int ld, input int fl,
                      input int est, input int ef1, input int ef2, input int etv, input int ecnt);
    exp_t e;
    @(posedge clk);
    #1;
    reset = 1'b1;
    drive(v, u1, s1, u2, s2, wr, d, ld, fl);
    e.dut = dut; e.id = step_no; e.st = est; e.f1 = ef1; e.f2 = ef2; e.tv = etv; e.cnt = ecnt;
    sb.push_back(e);
    step_no++;
  endtask

  task automatic hold_reset(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk);
      #1;
      reset = 1'b0;
      drive(1, 1, 3, 1, 3, 1, 3, 1, 0);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    hold_reset(2);
    step(0, 0,0,0,0,0,0,0,0,0, 0,0,0, 0, 0);
    // Back-to-back ALU dependency on r3
    step(0, 1,0,0,0,0,1,3,0,0, 0,0,0, 0, 0);
    step(0, 1,1,3,0,0,0,0,0,0, FWD?0:1, FWD?1:0, 0, 1, 0);
    step(0, 1,1,3,0,0,0,0,0,0, FWD?0:1, FWD?2:0, 0, 2, FWD?0:1);
    step(0, 0,0,0,0,0,0,0,0,0, 0,0,0, 4, FWD?0:2);
    step(0, 0,0,0,0,0,0,0,0,0, 0,0,0, 0, FWD?0:2);
    // Load-use on r5 through src2
    step(0, 1,0,0,0,0,1,5,1,0, 0,0,0, 0, FWD?0:2);
    step(0, 1,0,0,1,5,0,0,0,0, 1,0,0, 1, FWD?0:2);
    step(0, 1,0,0,1,5,0,0,0,0, FWD?0:1, 0, FWD?2:0, 2, FWD?1:3);
    step(0, 0,0,0,0,0,0,0,0,0, 0,0,0, 4, FWD?1:4);
    // Write r2 then read it while it walks through every stage
    step(0, 1,0,0,0,0,1,2,0,0, 0,0,0, 0, FWD?1:4);
    step(0, 1,1,2,0,0,0,0,0,0, FWD?0:1, FWD?1:0, 0, 1, FWD?1:4);
    step(0, 1,1,2,0,0,0,0,0,0, FWD?0:1, FWD?2:0, 0, 2, FWD?1:5);
    step(0, 1,1,2,0,0,0,0,0,0, FWD?0:1, FWD?3:0, 0, 4, FWD?1:6);
    step(0, 1,1,2,0,0,0,0,0,0, 0,0,0, 0, FWD?1:7);
    // Flushed write to r7 never becomes a producer
    step(0, 1,0,0,0,0,1,7,0,1, 0,0,0, 0, FWD?1:7);
    step(0, 1,1,7,1,7,0,0,0,0, 0,0,0, 0, FWD?1:7);
    // Flush while a hazard is present suppresses the stall
    step(0, 1,0,0,0,0,1,1,0,0, 0,0,0, 0, FWD?1:7);
    step(0, 1,1,1,0,0,0,0,0,1, 0, FWD?1:0, 0, 1, FWD?1:7);
    step(0, 0,0,0,0,0,0,0,0,0, 0,0,0, 2, FWD?1:7);

    hold_reset(1);
    // Depth 5, hardwired zero: r0 is never a hazard
    step(1, 1,0,0,0,0,1,0,0,0, 0,0,0, 0, 0);
    step(1, 1,1,0,1,0,0,0,0,0, 0,0,0, 0, 0);
    // Two writers of r4; the younger one (stage 2) must win
    step(1, 1,0,0,0,0,1,4,0,0, 0,0,0, 0, 0);
    step(1, 0,0,0,0,0,0,0,0,0, 0,0,0, 1, 0);
    step(1, 1,0,0,0,0,1,4,0,0, 0,0,0, 2, 0);
    step(1, 0,0,0,0,0,0,0,0,0, 0,0,0, 5, 0);
    step(1, 1,1,4,1,0,0,0,0,0, FWD?0:1, FWD?2:0, 0, 10, 0);
    step(1, 1,0,0,1,4,0,0,0,0, FWD?0:1, 0, FWD?3:0, 20, FWD?0:1);
    step(1, 0,0,0,0,0,0,0,0,0, 0,0,0, 8, FWD?0:2);

    for (int i = 0; i < 4 && sb.size() > 0; i++) @(negedge clk);
    #1;
    n_cmp++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
